// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, fixed 3-cycle turn.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is LSU priority.
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif
`ifndef Wdt8
`define Wdt8  4'b0001
`endif
`ifndef Wdt16
`define Wdt16 4'b0010
`endif
`ifndef Wdt32
`define Wdt32 4'b0100
`endif
`ifndef Wdt64
`define Wdt64 4'b1000
`endif

module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ifu_req_valid,
    output logic                   ifu_req_ready,
    input  logic [ADDR_W-1:0]      ifu_addr,
    output logic                   ifu_resp_valid,
    output logic [DATA_W-1:0]      ifu_rdata,
    input  logic                   lsu_req_valid,
    output logic                   lsu_req_ready,
    input  logic                   lsu_wen,
    input  logic [ADDR_W-1:0]      lsu_addr,
    input  logic [DATA_W-1:0]      lsu_wdata,
    input  logic [`WdtTypeCnt-1:0] lsu_wdt_op,
    output logic                   lsu_resp_valid,
    output logic [DATA_W-1:0]      lsu_rdata,
    output logic [ADDR_W-1:0]      mem_raddr,
    output logic [ADDR_W-1:0]      mem_waddr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_ren,
    output logic                   mem_wen,
    output logic [`WdtTypeCnt-1:0] wdt_op,
    input  logic [DATA_W-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic                   grant_ifu;
    logic                   grant_lsu;
    logic                   hs;
    logic                   issue;
    logic                   r_lsu;
    logic                   r_wen;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [`WdtTypeCnt-1:0] r_wdt;
    logic [31:0]            grant_cnt;
    logic                   unused_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu <= 1'b1;
        end else if (hs) begin
            last_lsu <= grant_lsu;
        end
    end
`endif

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst_n && state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_ifu = last_lsu;
                grant_lsu = ~last_lsu;
`else
                grant_lsu = 1'b1;
`endif
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign hs            = grant_ifu | grant_lsu;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            r_lsu          <= 1'b0;
            r_wen          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wdt          <= '0;
            grant_cnt      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
        end else begin
            state          <= state_nxt;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            if (hs) begin
                r_lsu     <= grant_lsu;
                r_wen     <= grant_lsu & lsu_wen;
                r_addr    <= grant_lsu ? lsu_addr : ifu_addr;
                r_wdata   <= (grant_lsu & lsu_wen) ? lsu_wdata : '0;
                r_wdt     <= grant_lsu ? lsu_wdt_op : `Wdt32;
                grant_cnt <= grant_cnt + 32'd1;
            end
            if (state == WAIT) begin
                if (r_lsu) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= r_wen ? '0 : mem_rdata;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= mem_rdata;
                end
            end
        end
    end

    // Memory port is quiet (all zero) except during the single ISSUE cycle.
    assign issue     = (state == ISSUE);
    assign mem_ren   = issue & ~r_wen;
    assign mem_wen   = issue & r_wen;
    assign mem_raddr = mem_ren ? r_addr : '0;
    assign mem_waddr = mem_wen ? r_addr : '0;
    assign mem_wdata = mem_wen ? r_wdata : '0;
    assign wdt_op    = issue ? r_wdt : '0;

    assign unused_cnt = ^grant_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised transaction-level check of mem_arbiter against a cycle-count model.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin variant.
`ifndef WdtTypeCnt
`define WdtTypeCnt 4
`endif
`ifndef Wdt32
`define Wdt32 4'b0100
`endif
`ifndef Wdt64
`define Wdt64 4'b1000
`endif

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [63:0] lsu_addr = '0;
    logic [63:0] lsu_wdata = '0;
    logic [3:0]  lsu_wdt_op = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  wdt_op;
    logic [63:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wdt_op(lsu_wdt_op), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .wdt_op(wdt_op), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic logic [63:0] seed_val(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[63:32]} + 64'h0123_4567_89AB_CDEF;
    endfunction

    // Memory behind the port: one-cycle read latency.
    logic [63:0] mem_store [logic [63:0]];
    always @(posedge clk) begin
        if (mem_ren)
            mem_rdata <= mem_store.exists(mem_raddr) ? mem_store[mem_raddr]
                                                     : seed_val(mem_raddr);
        if (mem_wen)
            mem_store[mem_waddr] = mem_wdata;
    end

    typedef struct {
        bit          lsu;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wdt;
    } txn_t;

    logic [63:0] ref_mem [logic [63:0]];
    txn_t        cur;
    logic [63:0] cur_rd;
    logic [63:0] exp_ifu_rd;
    logic [63:0] exp_lsu_rd;
    int          cyc;
    int          g_cyc;
    bit          m_last_lsu;
    int unsigned m_cnt;
    bit          ifu_hs;
    bit          lsu_hs;
    int          n_vec;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        g_cyc      = cyc - 1000;
        m_last_lsu = 1'b1;
        m_cnt      = 0;
        exp_ifu_rd = '0;
        exp_lsu_rd = '0;
        ifu_hs     = 1'b0;
        lsu_hs     = 1'b0;
    endtask

    // One clock of the model: a grant takes the port for 3 cycles, the
    // memory access is 1 cycle after it, the response 3 cycles after it.
    task automatic tick();
        int d;
        bit gi;
        bit gl;
        #1;
        d  = cyc - g_cyc;
        gi = 1'b0;
        gl = 1'b0;
        if (d >= 3) begin
            if (ifu_req_valid && lsu_req_valid) begin
                gi = RR ? m_last_lsu : 1'b0;
                gl = RR ? !m_last_lsu : 1'b1;
            end else begin
                gi = ifu_req_valid;
                gl = lsu_req_valid;
            end
        end
        check("ifu_ready", ifu_req_ready, gi);
        check("lsu_ready", lsu_req_ready, gl);
        if (d == 1) begin
            check("mem_ren", mem_ren, !cur.wen);
            check("mem_wen", mem_wen, cur.wen);
            check("wdt_op", wdt_op, cur.wdt);
            if (cur.wen) begin
                check("mem_waddr", mem_waddr, cur.addr);
                check("mem_wdata", mem_wdata, cur.wdata);
            end else begin
                check("mem_raddr", mem_raddr, cur.addr);
            end
        end else begin
            check("idle_ren", mem_ren, 0);
            check("idle_wen", mem_wen, 0);
            check("idle_raddr", mem_raddr, 0);
            check("idle_waddr", mem_waddr, 0);
            check("idle_wdata", mem_wdata, 0);
        end
        if (d == 3) begin
            if (cur.lsu) exp_lsu_rd = cur.wen ? 64'd0 : cur_rd;
            else         exp_ifu_rd = cur_rd;
        end
        check("ifu_resp_valid", ifu_resp_valid, d == 3 && !cur.lsu);
        check("lsu_resp_valid", lsu_resp_valid, d == 3 && cur.lsu);
        check("ifu_rdata", ifu_rdata, exp_ifu_rd);
        check("lsu_rdata", lsu_rdata, exp_lsu_rd);
        ifu_hs = gi;
        lsu_hs = gl;
        if (gi || gl) begin
            cur.lsu   = gl;
            cur.wen   = gl && lsu_wen;
            cur.addr  = gl ? lsu_addr : ifu_addr;
            cur.wdata = (gl && lsu_wen) ? lsu_wdata : 64'd0;
            cur.wdt   = gl ? lsu_wdt_op : `Wdt32;
            cur_rd    = ref_mem.exists(cur.addr) ? ref_mem[cur.addr]
                                                 : seed_val(cur.addr);
            if (cur.wen) ref_mem[cur.addr] = cur.wdata;
            g_cyc      = cyc;
            m_last_lsu = gl;
            m_cnt      = m_cnt + 1;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_hs(input bit lsu);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = lsu ? lsu_hs : ifu_hs;
        end
        check(lsu ? "lsu_hs_seen" : "ifu_hs_seen", got, 1);
    endtask

    task automatic run_ifu(input logic [63:0] a);
        ifu_req_valid = 1'b1;
        ifu_addr      = a;
        wait_hs(1'b0);
        ifu_req_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_lsu(input bit w, input logic [63:0] a,
                           input logic [63:0] wd, input logic [3:0] op);
        lsu_req_valid = 1'b1;
        lsu_wen       = w;
        lsu_addr      = a;
        lsu_wdata     = wd;
        lsu_wdt_op    = op;
    endtask

    function automatic logic [63:0] rnd_addr();
        return 64'h8000_0000 + 64'(8 * $urandom_range(0, 15));
    endfunction

    task automatic check_reset_outputs();
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_ifu_resp", ifu_resp_valid, 0);
        check("rst_lsu_resp", lsu_resp_valid, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_ifu_rdata", ifu_rdata, 0);
        check("rst_lsu_rdata", lsu_rdata, 0);
        check("rst_mem_raddr", mem_raddr, 0);
        check("rst_cnt", dut.grant_cnt, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          who;
        int          c1;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        model_reset();

        // Reset with both requests pending: nothing may be granted.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        run_ifu(64'h8000_0000);

        set_lsu(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, `Wdt64);
        wait_hs(1'b1);
        lsu_req_valid = 1'b0;
        repeat (3) tick();
        set_lsu(1'b0, 64'h8000_0010, 64'd0, `Wdt64);
        wait_hs(1'b1);
        lsu_req_valid = 1'b0;
        repeat (3) tick();

        // Both requesters saturating the port from a fresh reset.
        @(negedge clk);
        apply_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = rnd_addr();
        set_lsu(1'b0, rnd_addr(), 64'd0, `Wdt64);
        for (int k = 0; k < 6; k++) begin
            bit got;
            got = 1'b0;
            who = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                got = ifu_hs || lsu_hs;
                who = lsu_hs;
            end
            check("both_hs_seen", got, 1);
            check("grant_order", who, RR ? k % 2 : 1);
            if (who) lsu_addr = rnd_addr();
            else     ifu_addr = rnd_addr();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (3) tick();

        // Reset while the transaction sits in WAIT: it must vanish.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0040;
        wait_hs(1'b0);
        ifu_req_valid = 1'b0;
        tick();
        apply_reset();
        repeat (4) tick();
        run_ifu(64'h8000_0048);

        // Back-to-back loads: next grant lands on the response cycle.
        set_lsu(1'b0, rnd_addr(), 64'd0, `Wdt64);
        wait_hs(1'b1);
        c1 = cyc - 1;
        lsu_addr = rnd_addr();
        wait_hs(1'b1);
        check("b2b_gap", 64'(cyc - 1 - c1), 3);
        lsu_req_valid = 1'b0;
        repeat (3) tick();

        // Counter wrap: preset just below 2^32, then six grants.
        force dut.grant_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.grant_cnt;
        m_cnt = 32'hFFFF_FFFD;
        for (int k = 0; k < 6; k++) run_ifu(rnd_addr());
        check("cnt_wrap", dut.grant_cnt, 3);
        check("cnt_model", dut.grant_cnt, 64'(m_cnt));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ifu_hs || !ifu_req_valid) begin
                ifu_req_valid = ($urandom_range(0, 9) < 6);
                ifu_addr      = rnd_addr();
            end
            if (lsu_hs || !lsu_req_valid) begin
                lsu_req_valid = ($urandom_range(0, 9) < 6);
                lsu_wen       = $urandom_range(0, 1) == 1;
                lsu_addr      = rnd_addr();
                lsu_wdata     = {$urandom, $urandom};
                lsu_wdt_op    = 4'(1 << $urandom_range(0, 3));
            end
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (4) tick();
        check("cnt_final", dut.grant_cnt, 64'(m_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
